pe_accumulator: RTL

//   Downstream stage of signed_multiplier inside the PE: consumes each signed product (dout / data_out_valid)
//   and sums a programmed number of products into a wide signed accumulator.

---
 rtl/pe_accumulator_pkg.sv | 22 ++
 rtl/pe_accumulator_adder.sv | 42 ++++
 rtl/pe_accumulator.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pe_accumulator_pkg.sv
// Shared definitions for the PE accumulate stage: FSM state encoding,
// default accumulator guard width and a width helper.
package pe_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int ACC_GUARD_BITS = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pe_accumulator_adder.sv
// Combinational signed accumulate step with overflow detection.
// Build option ACC_SAT_EN clamps the sum on overflow instead of wrapping.
module pe_accumulator_adder
    import pe_accumulator_pkg::*;
#(
    parameter int BITWIDTH  = 8,
    parameter int ACC_WIDTH = 2*BITWIDTH + ACC_GUARD_BITS
) (
    input  logic [ACC_WIDTH-1:0]  i_acc,
    input  logic [2*BITWIDTH-1:0] i_prod,
    output logic [ACC_WIDTH-1:0]  o_sum,
    output logic                  o_overflow
);

    localparam int PW = 2*BITWIDTH;

    logic [ACC_WIDTH-1:0] w_prod_ext;
    logic [ACC_WIDTH-1:0] w_raw;
    logic                 w_ovf;

    assign w_prod_ext[PW-1:0] = i_prod;

    // Replicate the product sign bit into every guard bit
    for (genvar gi = PW; gi < ACC_WIDTH; gi++) begin : g_sign_ext
        assign w_prod_ext[gi] = i_prod[PW-1];
    end

    assign w_raw = i_acc + w_prod_ext;
    assign w_ovf = (i_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                   (w_raw[ACC_WIDTH-1] != i_acc[ACC_WIDTH-1]);

`ifdef ACC_SAT_EN
    assign o_sum = !w_ovf ? w_raw :
                   i_acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
    assign o_sum = w_raw;
`endif

    assign o_overflow = w_ovf;

endmodule

// File: rtl/pe_accumulator.sv
// PE accumulate stage: sums a programmed number of signed products and hands
// the result downstream with valid/ready. ACC_SAT_EN selects saturating adds.
module pe_accumulator
    import pe_accumulator_pkg::*;
#(
    parameter int BITWIDTH  = 8,
    parameter int ACC_WIDTH = 2*BITWIDTH + ACC_GUARD_BITS,
    parameter int LEN_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic                  i_prod_valid,
    input  logic [2*BITWIDTH-1:0] i_prod,
    output logic                  o_prod_ready,
    output logic                  o_acc_valid,
    input  logic                  i_acc_ready,
    output logic [ACC_WIDTH-1:0]  o_acc_out,
    output logic                  o_busy,
    output logic                  o_overflow,
    output logic                  o_dropped
);

    state_t               r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_acc_out;
    logic [LEN_WIDTH-1:0] r_count;
    logic [LEN_WIDTH-1:0] r_len;
    logic                 r_acc_valid;
    logic                 r_prod_ready;
    logic                 r_busy;
    logic                 r_overflow;
    logic                 r_dropped;

    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_add_ovf;
    logic                 w_start_ok;
    logic                 w_drop;
    logic                 w_last;

    pe_accumulator_adder #(
        .BITWIDTH  (BITWIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_adder (
        .i_acc      (r_acc),
        .i_prod     (i_prod),
        .o_sum      (w_sum),
        .o_overflow (w_add_ovf)
    );

    // A new job may start from IDLE, or from DONE in the same cycle the result is taken
    assign w_start_ok = i_start && ((r_state == ST_IDLE) ||
                                    ((r_state == ST_DONE) && i_acc_ready));
    assign w_drop     = i_prod_valid && (r_state != ST_ACCUM);
    assign w_last     = (r_count == (r_len - LEN_WIDTH'(1)));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_acc_out    <= '0;
            r_count      <= '0;
            r_len        <= '0;
            r_acc_valid  <= 1'b0;
            r_prod_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
            r_dropped    <= 1'b0;
        end else begin
            if (w_drop) begin
                r_dropped <= 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_len      <= i_len;
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_dropped  <= 1'b0;
                        r_busy     <= 1'b1;
                        if (i_len == '0) begin
                            r_state      <= ST_DONE;
                            r_acc_out    <= '0;
                            r_acc_valid  <= 1'b1;
                            r_prod_ready <= 1'b0;
                        end else begin
                            r_state      <= ST_ACCUM;
                            r_acc_valid  <= 1'b0;
                            r_prod_ready <= 1'b1;
                        end
                    end else if ((r_state == ST_DONE) && i_acc_ready) begin
                        r_state     <= ST_IDLE;
                        r_acc_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (i_prod_valid) begin
                        r_acc   <= w_sum;
                        r_count <= r_count + LEN_WIDTH'(1);
                        if (w_add_ovf) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_last) begin
                            r_state      <= ST_DONE;
                            r_acc_out    <= w_sum;
                            r_acc_valid  <= 1'b1;
                            r_prod_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_prod_ready = r_prod_ready;
    assign o_acc_valid  = r_acc_valid;
    assign o_acc_out    = r_acc_out;
    assign o_busy       = r_busy;
    assign o_overflow   = r_overflow;
    assign o_dropped    = r_dropped;

endmodule
